// File: rtl/fp16_pkg.sv
// Shared FP16 field widths, fixed-point scaling and flag bit positions
// for the multiplier and product-accumulator datapaths.
package fp16_pkg;

   localparam int FP_W        = 16;
   localparam int EXP_W       = 5;
   localparam int MAN_W       = 10;
   localparam int BIAS        = 15;
   localparam int FIX_LSB_EXP = -24;
   localparam int FLG_W       = 5;

   // multiplier flag vector
   localparam int MF_ANY_EXC  = 4;
   localparam int MF_ANAN     = 3;
   localparam int MF_BNAN     = 2;
   localparam int MF_AINF     = 1;
   localparam int MF_BINF     = 0;

   // accumulator flag vector
   localparam int AF_IN_EXC   = 4;
   localparam int AF_OVF      = 3;
   localparam int AF_UNF      = 2;
   localparam int AF_INEXACT  = 1;
   localparam int AF_ACC_SAT  = 0;

endpackage

// File: rtl/fp16_product_accumulator_if.sv
// Product stream in, reduced FP16 result out, each with valid/ready.
interface fp16_product_accumulator_if #(
   parameter int CNT_W = 8
);
   import fp16_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [FP_W-1:0]      in_data;
   logic [FLG_W-1:0]     in_flags;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [FP_W-1:0]      out_data;
   logic [FLG_W-1:0]     out_flags;
   logic [CNT_W-1:0]     out_count;

   modport master (
      output in_valid, in_data, in_flags, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_flags, out_count
   );

   modport slave (
      input  in_valid, in_data, in_flags, in_last, out_ready,
      output in_ready, out_valid, out_data, out_flags, out_count
   );

endinterface

// File: rtl/fp16_fix_normalize.sv
// Signed fixed-point (LSB 2^-24) to FP16 conversion with
// round-to-nearest-even; flushes tiny results to signed zero.
module fp16_fix_normalize
   import fp16_pkg::*;
#(
   parameter int ACC_W = 48
) (
   input  logic signed [ACC_W-1:0] sum_i,
   output logic [FP_W-1:0]         data_o,
   output logic                    ovf_o,
   output logic                    unf_o,
   output logic                    inx_o
);

   localparam int PW     = $clog2(ACC_W);
   localparam int EB_OFS = -FIX_LSB_EXP - BIAS;

   logic              sgn;
   logic [ACC_W-1:0]  mag;
   logic [ACC_W-1:0]  norm;
   logic [PW-1:0]     p;
   logic [PW+1:0]     eb;
   logic [PW+1:0]     eb_r;
   logic [MAN_W-1:0]  man;
   logic [MAN_W-1:0]  man_r;
   logic              g;
   logic              s;
   logic              rnd;
   logic              cy;

   always_comb begin
      sgn = sum_i[ACC_W-1];
      mag = sgn ? ACC_W'(-sum_i) : ACC_W'(sum_i);
      p   = '0;
      for (int i = 0; i < ACC_W; i++) begin
         if (mag[i]) p = PW'(i);
      end
      // left-justify so the hidden one sits in the MSB
      norm = mag << (PW'(ACC_W - 1) - p);
      man  = norm[ACC_W-2 -: MAN_W];
      g    = norm[ACC_W-2-MAN_W];
      s    = |norm[ACC_W-3-MAN_W:0];
      rnd  = g & (s | man[0]);
      {cy, man_r} = {1'b0, man} + (MAN_W+1)'(rnd);
      eb   = {2'b00, p} - (PW+2)'(EB_OFS);
      eb_r = eb + (PW+2)'(cy);

      data_o = '0;
      ovf_o  = 1'b0;
      unf_o  = 1'b0;
      inx_o  = 1'b0;
      if (mag != '0) begin
         if (eb[PW+1] || eb == '0) begin
            data_o = {sgn, 15'h0};
            unf_o  = 1'b1;
            inx_o  = 1'b1;
         end else if (eb_r >= (PW+2)'(31)) begin
            data_o = {sgn, 5'h1F, 10'h0};
            ovf_o  = 1'b1;
            inx_o  = g | s;
         end else begin
            data_o = {sgn, eb_r[EXP_W-1:0], man_r};
            inx_o  = g | s;
         end
      end
   end

endmodule

// File: rtl/fp16_product_accumulator.sv
// Exact fixed-point reduction of a vector of FP16 products, emitting
// one rounded FP16 sum with sticky flags and beat count per vector.
module fp16_product_accumulator
   import fp16_pkg::*;
#(
   parameter int ACC_W = 48,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   fp16_product_accumulator_if.slave  bus
);

   localparam logic [1:0] S_ACC  = 2'd0;
   localparam logic [1:0] S_NORM = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]              state_q, state_d;
   logic                    last_seen_q;
   logic                    s1_vld_q, s1_last_q;
   logic signed [ACC_W-1:0] s1_term_q, term_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    s2_last_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    exc_q, sat_q;
   logic                    out_vld_q;
   logic [FP_W-1:0]         out_data_q;
   logic [FLG_W-1:0]        out_flags_q;
   logic [CNT_W-1:0]        out_cnt_q;

   logic                    in_rdy, in_acc, out_hs;
   logic                    exc_beat, add_ovf;
   logic [EXP_W-1:0]        ex;
   logic [ACC_W-1:0]        mag;
   logic [ACC_W:0]          sum_w;
   logic [FP_W-1:0]         nrm_data;
   logic                    nrm_ovf, nrm_unf, nrm_inx;

   assign in_rdy = (state_q == S_ACC) && !last_seen_q;
   assign in_acc = bus.in_valid && in_rdy;
   assign out_hs = (state_q == S_HOLD) && bus.out_ready;

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_flags = out_flags_q;
   assign bus.out_count = out_cnt_q;

   always_comb begin
      ex       = bus.in_data[FP_W-2 -: EXP_W];
      mag      = '0;
      term_d   = '0;
      exc_beat = 1'b0;
      if (ex == 5'h1F || bus.in_flags[MF_ANY_EXC]) begin
         exc_beat = 1'b1;
      end else if (ex != '0) begin
         mag    = ACC_W'({1'b1, bus.in_data[MAN_W-1:0]}) << (ex - 5'd1);
         term_d = bus.in_data[FP_W-1] ? -$signed(mag) : $signed(mag);
      end
   end

   // one guard bit exposes signed overflow; clamp to full scale
   always_comb begin
      sum_w   = {acc_q[ACC_W-1], acc_q} + {s1_term_q[ACC_W-1], s1_term_q};
      add_ovf = sum_w[ACC_W] != sum_w[ACC_W-1];
      acc_d   = sum_w[ACC_W-1:0];
      if (add_ovf) begin
         acc_d = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         state_q == S_ACC:  if (s2_last_q) state_d = S_NORM;
         state_q == S_NORM: state_d = S_HOLD;
         state_q == S_HOLD: if (bus.out_ready) state_d = S_ACC;
         default:           state_d = S_ACC;
      endcase
   end

   fp16_fix_normalize #(.ACC_W(ACC_W)) u_norm (
      .sum_i  (acc_q),
      .data_o (nrm_data),
      .ovf_o  (nrm_ovf),
      .unf_o  (nrm_unf),
      .inx_o  (nrm_inx)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_ACC;
         last_seen_q <= 1'b0;
         s1_vld_q    <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_term_q   <= '0;
         acc_q       <= '0;
         s2_last_q   <= 1'b0;
         cnt_q       <= '0;
         exc_q       <= 1'b0;
         sat_q       <= 1'b0;
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_flags_q <= '0;
         out_cnt_q   <= '0;
      end else begin
         state_q   <= state_d;
         s1_vld_q  <= in_acc;
         s1_last_q <= in_acc && bus.in_last;
         s2_last_q <= s1_vld_q && s1_last_q;
         if (in_acc) begin
            s1_term_q <= term_d;
            if (bus.in_last) last_seen_q <= 1'b1;
            if (exc_beat) exc_q <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
         end
         if (s1_vld_q) begin
            acc_q <= acc_d;
            if (add_ovf) sat_q <= 1'b1;
         end
         if (state_q == S_NORM) begin
            out_vld_q   <= 1'b1;
            out_data_q  <= nrm_data;
            out_flags_q <= {exc_q, nrm_ovf, nrm_unf, nrm_inx, sat_q};
            out_cnt_q   <= cnt_q;
         end
         if (out_hs) begin
            out_vld_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            exc_q       <= 1'b0;
            sat_q       <= 1'b0;
            last_seen_q <= 1'b0;
         end
      end
   end

endmodule
